// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder: FSM states,
// default lane geometry and lane-slice helpers.
package mac_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } feed_state_e;

    localparam int DEF_N     = 5;
    localparam int DEF_WIDTH = 16;

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic int lane_hi(input int lane, input int width);
        return (lane + 1) * width - 1;
    endfunction

endpackage

// File: rtl/mac_feed_pipe.sv
// Two-stage tag/data pipe: stage 1 tracks the RAM read latency,
// stage 2 is the output register facing the MAC array.
module mac_feed_pipe
    import mac_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_valid_i,
    input  logic               rd_first_i,
    input  logic [N*WIDTH-1:0] a_rdata_i,
    input  logic [WIDTH-1:0]   b_rdata_i,
    output logic               s1_valid_o,
    output logic               s2_valid_o,
    output logic               sof_o,
    output logic [N*WIDTH-1:0] a_o,
    output logic [WIDTH-1:0]   b_o
);

    logic               s1_valid_q, s1_valid_d;
    logic               s1_first_q, s1_first_d;
    logic               s2_valid_q, s2_valid_d;
    logic               sof_q,      sof_d;
    logic [N*WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0]   b_q,        b_d;

    always_comb begin
        s1_valid_d = rd_valid_i;
        s1_first_d = rd_valid_i & rd_first_i;
        s2_valid_d = s1_valid_q;
        sof_d      = s1_valid_q & s1_first_q;
        b_d        = s1_valid_q ? b_rdata_i : '0;
    end

    // Idle lanes are forced to zero so the array accumulates nothing.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign a_d[lane_hi(i, WIDTH):lane_lo(i, WIDTH)] =
            s1_valid_q ? a_rdata_i[lane_hi(i, WIDTH):lane_lo(i, WIDTH)]
                       : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sof_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            s2_valid_q <= s2_valid_d;
            sof_q      <= sof_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    assign s1_valid_o = s1_valid_q;
    assign s2_valid_o = s2_valid_q;
    assign sof_o      = sof_q;
    assign a_o        = a_q;
    assign b_o        = b_q;

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams K-long operand frames from the A/B RAM banks into the
// parallel MAC array, one frame per output column.
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LW    = 8,
    parameter int AAW   = 8,
    parameter int BAW   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LW-1:0]      len,
    input  logic [LW-1:0]      frames,
    input  logic [AAW-1:0]     a_base,
    input  logic [BAW-1:0]     b_base,
    output logic               a_rd_en,
    output logic [AAW-1:0]     a_addr,
    input  logic [N*WIDTH-1:0] a_rdata,
    output logic               b_rd_en,
    output logic [BAW-1:0]     b_addr,
    input  logic [WIDTH-1:0]   b_rdata,
    output logic               sof,
    output logic [N*WIDTH-1:0] A,
    output logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done
);

    feed_state_e    state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  frames_q, frames_d;
    logic [LW-1:0]  k_q, k_d;
    logic [LW-1:0]  j_q, j_d;
    logic [AAW-1:0] abase_q, abase_d;
    logic [AAW-1:0] aaddr_q, aaddr_d;
    logic [BAW-1:0] baddr_q, baddr_d;

    logic rd_valid;
    logic rd_first;
    logic s1_valid;
    logic s2_valid;
    logic last_k;

    assign last_k = (k_q == len_q - LW'(1));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        frames_d = frames_q;
        k_d      = k_q;
        j_d      = j_q;
        abase_d  = abase_q;
        aaddr_d  = aaddr_q;
        baddr_d  = baddr_q;
        rd_valid = 1'b0;
        rd_first = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = len;
                    frames_d = frames;
                    abase_d  = a_base;
                    aaddr_d  = a_base;
                    baddr_d  = b_base;
                    k_d      = '0;
                    j_d      = '0;
                    if (len == '0 || frames == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                rd_valid = 1'b1;
                rd_first = (k_q == '0);
                // B is column-major and contiguous, so it never rewinds.
                baddr_d  = baddr_q + BAW'(1);
                if (last_k) begin
                    k_d     = '0;
                    aaddr_d = abase_q;
                    j_d     = j_q + LW'(1);
                    if (j_q == frames_q - LW'(1))
                        state_d = S_DRAIN;
                end else begin
                    k_d     = k_q + LW'(1);
                    aaddr_d = aaddr_q + AAW'(1);
                end
            end
            S_DRAIN: begin
                // Last pair reaches the output register on the next edge.
                if (!s1_valid)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            frames_q <= '0;
            k_q      <= '0;
            j_q      <= '0;
            abase_q  <= '0;
            aaddr_q  <= '0;
            baddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            frames_q <= frames_d;
            k_q      <= k_d;
            j_q      <= j_d;
            abase_q  <= abase_d;
            aaddr_q  <= aaddr_d;
            baddr_q  <= baddr_d;
        end
    end

    assign a_rd_en = rd_valid;
    assign b_rd_en = rd_valid;
    assign a_addr  = rd_valid ? aaddr_q : '0;
    assign b_addr  = rd_valid ? baddr_q : '0;
    assign busy    = (state_q != S_IDLE);

    mac_feed_pipe #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .rd_valid_i (rd_valid),
        .rd_first_i (rd_first),
        .a_rdata_i  (a_rdata),
        .b_rdata_i  (b_rdata),
        .s1_valid_o (s1_valid),
        .s2_valid_o (s2_valid),
        .sof_o      (sof),
        .a_o        (A),
        .b_o        (B)
    );

    logic unused_ok;
    assign unused_ok = s2_valid;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench for mac_operand_feeder with behavioural A/B RAMs
// (A word at addr = {N{addr+1}}, B word at addr = addr+100).
module tb_mac_operand_feeder;

    localparam int N   = 5;
    localparam int W   = 16;
    localparam int LW  = 8;
    localparam int AAW = 8;
    localparam int BAW = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [LW-1:0]  len = '0;
    logic [LW-1:0]  frames = '0;
    logic [AAW-1:0] a_base = '0;
    logic [BAW-1:0] b_base = '0;
    logic           a_rd_en, b_rd_en;
    logic [AAW-1:0] a_addr;
    logic [BAW-1:0] b_addr;
    logic [N*W-1:0] a_rdata = '0;
    logic [W-1:0]   b_rdata = '0;
    logic           sof, busy, done;
    logic [N*W-1:0] A;
    logic [W-1:0]   B;

    always #5 clk = ~clk;

    mac_operand_feeder #(
        .N(N), .WIDTH(W), .LW(LW), .AAW(AAW), .BAW(BAW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .frames(frames), .a_base(a_base), .b_base(b_base),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
        .sof(sof), .A(A), .B(B), .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= {N{W'(a_addr) + 16'd1}};
        if (b_rd_en) b_rdata <= W'(b_addr) + 16'd100;
    end

    int rdcnt = 0;
    always @(posedge clk) if (a_rd_en) rdcnt <= rdcnt + 1;

    typedef struct packed {
        logic           sof;
        logic [N*W-1:0] a;
        logic [W-1:0]   b;
    } exp_t;
    exp_t q[$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && (sof || A != '0 || B != '0)) begin
            if (q.size() == 0) begin
                chk("unexpected pair", {sof, A, B}, '0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pair sof", sof, e.sof);
                chk("pair A", A, e.a);
                chk("pair B", B, e.b);
            end
        end
    end

    task automatic push_job(input int k, input int p, input int ab,
                            input int bb);
        exp_t e;
        logic [W-1:0] av;
        for (int j = 0; j < p; j++) begin
            for (int kk = 0; kk < k; kk++) begin
                av    = W'((ab + kk) % 256 + 1);
                e.sof = (kk == 0);
                e.a   = {N{av}};
                e.b   = W'((bb + j * k + kk) % 4096 + 100);
                q.push_back(e);
            end
        end
    endtask

    task automatic run_job(input int k, input int p, input int ab,
                           input int bb, input bit repulse);
        int n;
        int exp_n;
        bit got;
        push_job(k, p, ab, bb);
        rdcnt = 0;
        @(negedge clk);
        len    = LW'(k);
        frames = LW'(p);
        a_base = AAW'(ab);
        b_base = BAW'(bb);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy in job", busy, 1'b1);
            if (repulse && n == 2) begin
                start  = 1'b1;
                len    = 8'd7;
                frames = 8'd9;
            end
            if (repulse && n == 3) start = 1'b0;
            if (n == 3 && k * p > 0) chk("first sof", sof, 1'b1);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        exp_n = (k * p == 0) ? 1 : k * p + 3;
        chk("done cycle", got ? n : -1, exp_n);
        chk("queue drained", q.size(), 0);
        chk("read count", rdcnt, k * p);
        @(negedge clk);
        chk("done width", done, 1'b0);
        chk("busy after", busy, 1'b0);
    endtask

    initial begin
        int dcnt;
        #1;
        chk("rst sof", sof, 1'b0);
        chk("rst A", A, '0);
        chk("rst B", B, '0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst rd_en", a_rd_en, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_job(4, 1, 0, 0, 1'b0);
        run_job(3, 2, 0, 10, 1'b0);
        run_job(1, 3, 0, 0, 1'b0);
        run_job(0, 5, 0, 0, 1'b0);
        run_job(3, 0, 0, 0, 1'b0);
        run_job(2, 2, 7, 4094, 1'b0);
        run_job(3, 2, 0, 0, 1'b1);

        // Abort a 3x3 job in its second frame.
        push_job(3, 3, 0, 0);
        @(negedge clk);
        len    = 8'd3;
        frames = 8'd3;
        a_base = '0;
        b_base = '0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort sof", sof, 1'b0);
        chk("abort A", A, '0);
        chk("abort B", B, '0);
        chk("abort busy", busy, 1'b0);
        chk("abort rd_en", a_rd_en, 1'b0);
        q.delete();
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no done after abort", dcnt, 0);
        run_job(2, 2, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
